// File: rtl/wb_mem_slave.sv
// Wishbone single-access memory slave with programmable wait states.
// Define WB_MEM_ERR_EN to flag out-of-range addresses with err_o instead of wrapping.
module wb_mem_slave #(
   parameter int AWIDTH      = 32,
   parameter int DWIDTH      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic [AWIDTH-1:0] adr_i,
   input  logic [DWIDTH-1:0] dat_i,
   output logic [DWIDTH-1:0] dat_o,
   input  logic              we_i,
   input  logic              cyc_i,
   input  logic              stb_i,
   output logic              ack_o,
   output logic              err_o
);

   // state  | meaning
   // S_IDLE | waiting for cyc_i & stb_i
   // S_WAIT | counting wait states, abort if cyc_i drops
   // S_ACK  | one-cycle ack/err pulse, always back to idle (dead cycle)
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   localparam int IDX = $clog2(DEPTH);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX-1:0]    adr_q;
   logic [DWIDTH-1:0] dat_q;
   logic              we_q, err_q;
   logic              req, oor;
   logic              commit;
   logic [IDX-1:0]    c_adr;
   logic [DWIDTH-1:0] c_dat;
   logic              c_we, c_err;

   logic [DWIDTH-1:0] mem [DEPTH];

   assign req = cyc_i & stb_i;

`ifdef WB_MEM_ERR_EN
   assign oor = (adr_i >> IDX) != '0;
`else
   assign oor = 1'b0;
`endif

   // With zero wait states the commit happens on the capture edge, so it uses live inputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      c_adr   = adr_q;
      c_dat   = dat_q;
      c_we    = we_q;
      c_err   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               cnt_d = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  state_d = S_ACK;
                  commit  = 1'b1;
                  c_adr   = adr_i[IDX-1:0];
                  c_dat   = dat_i;
                  c_we    = we_i;
                  c_err   = oor;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (!cyc_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd1) begin
               state_d = S_ACK;
               commit  = 1'b1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         dat_o   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_IDLE && req) begin
            adr_q <= adr_i[IDX-1:0];
            dat_q <= dat_i;
            we_q  <= we_i;
            err_q <= oor;
         end
         if (commit && !c_we && !c_err) dat_o <= mem[c_adr];
      end
   end

   // Memory is not reset; writes are suppressed on a reset edge.
   always_ff @(posedge hclk) begin
      if (hresetn && commit && c_we && !c_err) mem[c_adr] <= c_dat;
   end

   assign ack_o = (state_q == S_ACK) & ~err_q;
`ifdef WB_MEM_ERR_EN
   assign err_o = (state_q == S_ACK) & err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_slave.sv
// Randomized self-checking bench for wb_mem_slave; three instances with 0, 1 and 3 wait states.
module tb_wb_mem_slave;

`ifdef WB_MEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic            hclk = 1'b0;
   logic            hresetn;
   logic [2:0][31:0] adr, dat_w, dat_r;
   logic [2:0]      we, cyc, stb, ack, err;

   logic [31:0] model   [3][256];
   logic [31:0] last_rd [3];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 hclk = ~hclk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      wb_mem_slave #(
         .AWIDTH(32), .DWIDTH(32), .DEPTH(256),
         .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : 3)
      ) u_dut (
         .hclk(hclk), .hresetn(hresetn),
         .adr_i(adr[g]), .dat_i(dat_w[g]), .dat_o(dat_r[g]),
         .we_i(we[g]), .cyc_i(cyc[g]), .stb_i(stb[g]),
         .ack_o(ack[g]), .err_o(err[g])
      );
   end

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 1 : 3;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Request already driven; waits from the sampling edge through the ack/err pulse.
   task automatic finish_xfer(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
      bit oor;
      int lat;
      logic [31:0] exp_dat;
      oor = ERR_EN && ((a >> 8) != 0);
      lat = -1;
      @(posedge hclk);
      #1;
      adr[k]   = $urandom;
      dat_w[k] = $urandom;
      we[k]    = ~w;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) begin
            @(posedge hclk);
            #1;
         end
         if (ack[k] || err[k]) begin
            lat = i;
            break;
         end
      end
      check_eq("latency", lat, ws_of(k));
      check_eq("ack", {31'd0, ack[k]}, {31'd0, ~oor});
      check_eq("err", {31'd0, err[k]}, {31'd0, oor});
      exp_dat = (!w && !oor) ? model[k][a[7:0]] : last_rd[k];
      check_eq(w ? "dat_o_hold_wr" : "dat_o_rd", dat_r[k], exp_dat);
      last_rd[k] = exp_dat;
      if (w && !oor) model[k][a[7:0]] = d;
      @(negedge hclk);
      cyc[k] = 1'b0;
      stb[k] = 1'b0;
      @(posedge hclk);
      #1;
      check_eq("pulse_len", {30'd0, err[k], ack[k]}, 32'd0);
   endtask

   task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
      @(negedge hclk);
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat_w[k] = d;
      finish_xfer(k, w, a, d);
   endtask

   initial begin
      int seen;
      logic [31:0] a;
      hresetn = 1'b0;
      adr = '0; dat_w = '0; we = '0; cyc = '0; stb = '0;
      for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;

      // Reset held with a pending write request on instance 1.
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h5; dat_w[1] = 32'hA5A5_0005;
      repeat (2) begin
         @(posedge hclk);
         #1;
         check_eq("rst_ack", {29'd0, ack}, 32'd0);
         check_eq("rst_err", {29'd0, err}, 32'd0);
         check_eq("rst_dat", dat_r[1], 32'd0);
      end
      @(negedge hclk);
      hresetn = 1'b1;
      finish_xfer(1, 1'b1, 32'h5, 32'hA5A5_0005);

      // Initialise the low 32 words of every instance.
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 32; i++) xfer(k, 1'b1, i, $urandom);

      for (int k = 0; k < 3; k++) begin
         xfer(k, 1'b1, 32'h10, 32'hDEAD_BEEF);
         xfer(k, 1'b0, 32'h10, 32'h0);
         check_eq("deadbeef", dat_r[k], 32'hDEAD_BEEF);

         // Held strobe: accepts every WS+2 cycles, nothing during the dead cycle.
         @(negedge hclk);
         cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0; adr[k] = 32'h10;
         for (int i = 0; i < 12; i++) begin
            @(posedge hclk);
            #1;
            check_eq("held_ack", {31'd0, ack[k]},
                     {31'd0, (i >= ws_of(k)) && ((i - ws_of(k)) % (ws_of(k) + 2) == 0)});
         end
         last_rd[k] = model[k][16];
         @(negedge hclk);
         cyc[k] = 1'b0; stb[k] = 1'b0;
         repeat (ws_of(k) + 3) @(posedge hclk);
         check_eq("held_dat", dat_r[k], last_rd[k]);

         // Out-of-range / wrapping address.
         xfer(k, 1'b1, 32'h100, 32'h1234_5678);
         xfer(k, 1'b0, 32'h0, 32'h0);
      end

      // Abort in WAIT on the 3-wait-state instance.
      @(negedge hclk);
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h4; dat_w[2] = 32'h5;
      @(posedge hclk);
      @(negedge hclk);
      cyc[2] = 1'b0; stb[2] = 1'b0;
      seen = 0;
      for (int i = 0; i < 7; i++) begin
         @(posedge hclk);
         #1;
         if (ack[2] || err[2]) seen++;
      end
      check_eq("abort_ack", seen, 0);
      xfer(2, 1'b0, 32'h4, 32'h0);

      // Reset in the middle of WAIT.
      @(negedge hclk);
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h8; dat_w[2] = 32'h77;
      @(posedge hclk);
      @(negedge hclk);
      hresetn = 1'b0;
      @(posedge hclk);
      #1;
      check_eq("midrst_ack", {31'd0, ack[2]}, 32'd0);
      check_eq("midrst_dat2", dat_r[2], 32'd0);
      check_eq("midrst_dat0", dat_r[0], 32'd0);
      for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
      @(negedge hclk);
      hresetn = 1'b1;
      cyc[2] = 1'b0; stb[2] = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge hclk);
         #1;
         if (ack[2]) seen++;
      end
      check_eq("midrst_noack", seen, 0);
      xfer(2, 1'b0, 32'h8, 32'h0);

      // Random traffic against the model.
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 25; n++) begin
            a = $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = a | ($urandom_range(1, 255) << 8);
            xfer(k, $urandom_range(0, 1) == 1, a, $urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
